// File: rtl/mult_ctrl_pkg.sv
// Shared multiplier definitions: op encoding, sequencer states and the
// operand-signedness decode also used by the multiplier itself.
package mult_ctrl_pkg;

   typedef enum logic [1:0] {
      MUL    = 2'd0,
      MULH   = 2'd1,
      MULHSU = 2'd2,
      MULHU  = 2'd3
   } mult_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mult_ctrl_state_e;

   // {sign_a, sign_b}: which operands are treated as signed for the product
   function automatic logic [1:0] mult_signs(input mult_op_e op);
      case (op)
         MULH:    return 2'b11;
         MULHSU:  return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mult_ctrl.sv
// Sequencer in front of the combinational multiplier. Registers operands,
// holds them MUL_CYCLES cycles, returns the selected half of the product and
// caches the last product so a matching follow-up op completes in one cycle.
module mult_ctrl
   import mult_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES   = 2,
   parameter int ENABLE_REUSE = 1,
   parameter int TAG_W        = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  mult_op_e         req_op_i,
   input  logic [31:0]      req_a_i,
   input  logic [31:0]      req_b_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [31:0]      resp_result_o,
   output logic [TAG_W-1:0] resp_tag_o,
   output logic             mul_en_o,
   output mult_op_e         mul_op_o,
   output logic [31:0]      mul_a_o,
   output logic [31:0]      mul_b_o,
   input  logic [63:0]      mul_result_i
);

   localparam int CNT_W = $clog2(MUL_CYCLES + 1);

   mult_ctrl_state_e r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [TAG_W-1:0] r_tag;
   logic             r_cache_vld;
   logic [31:0]      r_cache_a, r_cache_b;
   logic [1:0]       r_cache_signs;
   logic [63:0]      r_cache_prod;
   logic             w_accept, w_hit;

   // MUL returns the low word, every MULH* variant the high word
   function automatic logic [31:0] sel_half(input mult_op_e op, input logic [63:0] prod);
      return (op == MUL) ? prod[31:0] : prod[63:32];
   endfunction

   assign req_ready_o  = (r_state == IDLE) & ~flush_i;
   assign resp_valid_o = (r_state == DONE);
   assign mul_en_o     = (r_state == CALC);
   assign w_accept     = req_valid_i & req_ready_o;

   // Low word is sign-independent, so MUL hits regardless of cached signedness
   assign w_hit = (ENABLE_REUSE != 0) && r_cache_vld &&
                  (req_a_i == r_cache_a) && (req_b_i == r_cache_b) &&
                  ((req_op_i == MUL) || (mult_signs(req_op_i) == r_cache_signs));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode; flush overrides every transition
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = w_hit ? DONE : CALC;
         CALC:    if (r_cnt == '0) w_next = DONE;
         DONE:    if (resp_ready_i) w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (flush_i) w_next = IDLE;
   end

   // Operand, counter, cache and response registers; flush freezes them all,
   // which leaves the cache untouched when an op is killed in CALC
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_tag         <= '0;
         r_cache_vld   <= 1'b0;
         r_cache_a     <= '0;
         r_cache_b     <= '0;
         r_cache_signs <= '0;
         r_cache_prod  <= '0;
         mul_op_o      <= MUL;
         mul_a_o       <= '0;
         mul_b_o       <= '0;
         resp_result_o <= '0;
         resp_tag_o    <= '0;
      end else if (!flush_i) begin
         if (r_state == IDLE && w_accept) begin
            if (w_hit) begin
               resp_result_o <= sel_half(req_op_i, r_cache_prod);
               resp_tag_o    <= req_tag_i;
            end else begin
               mul_op_o <= req_op_i;
               mul_a_o  <= req_a_i;
               mul_b_o  <= req_b_i;
               r_tag    <= req_tag_i;
               r_cnt    <= CNT_W'(MUL_CYCLES - 1);
            end
         end else if (r_state == CALC) begin
            if (r_cnt != '0) begin
               r_cnt <= r_cnt - 1'b1;
            end else begin
               r_cache_vld   <= 1'b1;
               r_cache_a     <= mul_a_o;
               r_cache_b     <= mul_b_o;
               r_cache_signs <= mult_signs(mul_op_o);
               r_cache_prod  <= mul_result_i;
               resp_result_o <= sel_half(mul_op_o, mul_result_i);
               resp_tag_o    <= r_tag;
            end
         end
      end
   end

endmodule

// File: tb/tb_mult_ctrl.sv
// Scoreboard bench for mult_ctrl: a driver issues requests and queues the
// expected result/tag/latency; a monitor checks each presented response.
module tb_mult_ctrl;
   import mult_ctrl_pkg::*;

   localparam int MC = 2;
   localparam int TW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush_i = 1'b0;
   logic          req_valid_i = 1'b0;
   mult_op_e      req_op_i = MUL;
   logic [31:0]   req_a_i = '0;
   logic [31:0]   req_b_i = '0;
   logic [TW-1:0] req_tag_i = '0;
   logic          resp_ready_i = 1'b0;
   logic          req_ready_o, resp_valid_o, mul_en_o;
   logic [31:0]   resp_result_o, mul_a_o, mul_b_o;
   logic [TW-1:0] resp_tag_o;
   mult_op_e      mul_op_o;
   logic [63:0]   mul_result_i;

   mult_ctrl #(.MUL_CYCLES(MC), .ENABLE_REUSE(1), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_result_o(resp_result_o), .resp_tag_o(resp_tag_o),
      .mul_en_o(mul_en_o), .mul_op_o(mul_op_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
      .mul_result_i(mul_result_i)
   );

   always #5 clk = ~clk;

   // Reference arithmetic: sign- or zero-extend each operand, 64-bit product
   function automatic logic [63:0] ref_prod(input mult_op_e op, input logic [31:0] a, input logic [31:0] b);
      logic sa, sb;
      logic [63:0] ea, eb;
      sa = (op == MULH) || (op == MULHSU);
      sb = (op == MULH);
      ea = sa ? {{32{a[31]}}, a} : {32'h0, a};
      eb = sb ? {{32{b[31]}}, b} : {32'h0, b};
      return ea * eb;
   endfunction

   function automatic logic [31:0] ref_result(input mult_op_e op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = ref_prod(op, a, b);
      return (op == MUL) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [1:0] ref_signs(input mult_op_e op);
      if (op == MULH)   return 2'b11;
      if (op == MULHSU) return 2'b10;
      return 2'b00;
   endfunction

   // External combinational multiplier beside the sequencer
   assign mul_result_i = ref_prod(mul_op_o, mul_a_o, mul_b_o);

   typedef struct {
      logic [31:0]   res;
      logic [TW-1:0] tag;
      int            acc;
      int            lat;
   } exp_t;

   exp_t        sbq[$];
   int          total = 0, bad = 0, cyc = 0;
   bit          done = 0;
   int          rr_mode = 2;   // 0 random, 1 hold low, 2 hold high
   bit          mvld = 0;
   logic [31:0] ma = '0, mb = '0;
   logic [1:0]  msg = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (rr_mode)
         0:       resp_ready_i = ($urandom_range(0, 3) != 0);
         1:       resp_ready_i = 1'b0;
         default: resp_ready_i = 1'b1;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   task automatic issue(input mult_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TW-1:0] tag, input bit use_exp, input logic [31:0] fexp);
      exp_t e;
      bit   h;
      int   n;
      h = mvld && (a == ma) && (b == mb) && ((op == MUL) || (ref_signs(op) == msg));
      @(posedge clk); #1;
      req_valid_i = 1'b1; req_op_i = op; req_a_i = a; req_b_i = b; req_tag_i = tag;
      n = 0;
      @(negedge clk);
      while (!req_ready_o && n < 60) begin n++; @(negedge clk); end
      if (!req_ready_o) begin
         flag_fail("accept_timeout");
         req_valid_i = 1'b0;
         return;
      end
      e.res = use_exp ? fexp : ref_result(op, a, b);
      e.tag = tag;
      e.acc = cyc;
      e.lat = h ? 1 : MC + 1;
      sbq.push_back(e);
      if (!h) begin mvld = 1; ma = a; mb = b; msg = ref_signs(op); end
      @(posedge clk); #1;
      req_valid_i = 1'b0;
   endtask

   task automatic wait_resp();
      int n = 0;
      @(negedge clk);
      while (!resp_valid_o && n < 60) begin n++; @(negedge clk); end
      if (!resp_valid_o) flag_fail("resp_timeout");
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!req_ready_o && n < 100) begin n++; @(negedge clk); end
      if (!req_ready_o) flag_fail("idle_timeout");
   endtask

   task automatic monitor();
      bit            pv = 0, pr = 0, pf = 0;
      logic [31:0]   lr = '0;
      logic [TW-1:0] lt = '0;
      exp_t          e;
      while (!done) begin
         @(negedge clk);
         if (rst_n) begin
            if (resp_valid_o && !pv) begin
               if (sbq.size() == 0) flag_fail("unexpected_resp");
               else begin
                  e = sbq.pop_front();
                  chk("resp_result", 64'(resp_result_o), 64'(e.res));
                  chk("resp_tag", 64'(resp_tag_o), 64'(e.tag));
                  chk("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
               end
            end else if (resp_valid_o && pv) begin
               chk("hold_result", 64'(resp_result_o), 64'(lr));
               chk("hold_tag", 64'(resp_tag_o), 64'(lt));
            end else if (!resp_valid_o && pv && !pr && !pf) begin
               flag_fail("valid_dropped_without_ready");
            end
         end
         pv = rst_n && resp_valid_o;
         pr = resp_ready_i;
         pf = flush_i;
         lr = resp_result_o;
         lt = resp_tag_o;
      end
   endtask

   task automatic main_seq();
      logic [31:0] pool[5];
      logic [31:0] la, lb, a, b;
      bit          sv;
      logic [31:0] sa, sb;
      logic [1:0]  ss;
      pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF; pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_resp_valid", 64'(resp_valid_o), 0);
      chk("rst_mul_en", 64'(mul_en_o), 0);
      chk("rst_result", 64'(resp_result_o), 0);
      chk("rst_tag", 64'(resp_tag_o), 0);
      chk("rst_mul_op", 64'(mul_op_o), 64'(MUL));
      chk("rst_mul_a", 64'(mul_a_o), 0);
      chk("rst_mul_b", 64'(mul_b_o), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // directed arithmetic and reuse cases
      issue(MUL, 32'h3, 32'hFFFF_FFFF, 5'h0A, 1, 32'hFFFF_FFFD); wait_idle();
      issue(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h01, 1, 32'h0); wait_idle();
      issue(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h02, 1, 32'h1);
      @(negedge clk);
      chk("hit_mul_en_low", 64'(mul_en_o), 0);
      wait_idle();
      issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, 1, 32'hFFFF_FFFE); wait_idle();
      issue(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h04, 1, 32'h0); wait_idle();
      issue(MULHSU, 32'h8000_0000, 32'h2, 5'h05, 1, 32'hFFFF_FFFF); wait_idle();

      // stalled response
      rr_mode = 1;
      issue(MUL, 32'd7, 32'd9, 5'h06, 1, 32'd63);
      wait_resp();
      repeat (5) begin
         @(negedge clk);
         chk("stall_valid", 64'(resp_valid_o), 1);
         chk("stall_req_ready", 64'(req_ready_o), 0);
      end
      rr_mode = 2;
      wait_idle();

      // flush in CALC cycle 1: no response, cache untouched
      sv = mvld; sa = ma; sb = mb; ss = msg;
      issue(MUL, 32'h1234, 32'h5678, 5'h07, 0, 32'h0);
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      if (sbq.size() > 0) void'(sbq.pop_back());
      mvld = sv; ma = sa; mb = sb; msg = ss;
      @(negedge clk);
      chk("flush_calc_idle", 64'(req_ready_o), 1);
      chk("flush_calc_no_resp", 64'(resp_valid_o), 0);
      issue(MUL, 32'h1234, 32'h5678, 5'h08, 0, 32'h0); wait_idle();

      // flush together with a request in IDLE
      @(posedge clk); #1;
      req_valid_i = 1'b1; req_op_i = MULHU; req_a_i = 32'hAAAA; req_b_i = 32'h5555; req_tag_i = 5'h09;
      flush_i = 1'b1;
      @(negedge clk);
      chk("flush_req_ready_low", 64'(req_ready_o), 0);
      @(posedge clk); #1;
      req_valid_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      chk("flush_req_no_calc", 64'(mul_en_o), 0);
      chk("flush_req_no_resp", 64'(resp_valid_o), 0);

      // flush in DONE: response dropped, cache kept
      rr_mode = 1;
      issue(MULHU, 32'hDEAD_BEEF, 32'h1357_9BDF, 5'h0B, 0, 32'h0);
      wait_resp();
      @(posedge clk); #1;
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      rr_mode = 2;
      @(negedge clk);
      chk("flush_done_drop", 64'(resp_valid_o), 0);
      issue(MULHU, 32'hDEAD_BEEF, 32'h1357_9BDF, 5'h0C, 0, 32'h0); wait_idle();

      // reset in DONE: response gone, cache invalidated
      rr_mode = 1;
      issue(MULH, 32'hCAFE_0001, 32'h8765_4321, 5'h0D, 0, 32'h0);
      wait_resp();
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      rr_mode = 2;
      mvld = 0;
      @(negedge clk);
      chk("rst_done_drop", 64'(resp_valid_o), 0);
      issue(MULH, 32'hCAFE_0001, 32'h8765_4321, 5'h0E, 0, 32'h0); wait_idle();

      // randomized traffic with frequent operand reuse
      rr_mode = 0;
      la = 32'h0; lb = 32'h0;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) < 4) begin
            a = la; b = lb;
         end else begin
            a = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 4)] : 32'($urandom);
            b = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 4)] : 32'($urandom);
         end
         issue(mult_op_e'(2'($urandom_range(0, 3))), a, b, TW'($urandom), 0, 32'h0);
         la = a; lb = b;
      end
      rr_mode = 2;
      begin
         int n = 0;
         while (sbq.size() != 0 && n < 200) begin n++; @(negedge clk); end
         if (sbq.size() != 0) flag_fail("scoreboard_not_drained");
      end
      wait_idle();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      fork
         monitor();
         begin
            main_seq();
            done = 1;
         end
      join
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
